// File: rtl/crossing_sequencer_if.sv
// Sensor/predictor/gate bundle for the grade-crossing sequencer.
// master = environment side (sensors, predictor), slave = sequencer.
interface crossing_sequencer_if #(
  parameter int unsigned TW = 19
);
  logic          tick;
  logic          s1;
  logic          s2;
  logic          s3;
  logic [TW-1:0] pred_time;
  logic [TW-1:0] meas_time;
  logic          pred_start;
  logic          gate_close;
  logic          busy;
  logic [2:0]    state;
  logic          err;

  modport master (
    output tick, s1, s2, s3, pred_time,
    input  meas_time, pred_start, gate_close, busy, state, err
  );

  modport slave (
    input  tick, s1, s2, s3, pred_time,
    output meas_time, pred_start, gate_close, busy, state, err
  );
endinterface

// File: rtl/crossing_sequencer.sv
// Grade-crossing cycle sequencer: measures s1->s2, hands the interval to the
// arrival predictor, counts down its prediction and holds the gate until clear.
module crossing_sequencer #(
  parameter int unsigned TW         = 19,
  parameter int unsigned PRED_LAT   = 1,
  parameter int unsigned HOLD_TICKS = 500
) (
  input  logic                 clk,
  input  logic                 rst,
  crossing_sequencer_if.slave  bus
);

  localparam int unsigned   LW         = $clog2(PRED_LAT + 2);
  localparam logic [TW-1:0] CNT_MAX    = '1;
  localparam logic [TW-1:0] CNT_PRESAT = CNT_MAX - TW'(1);
  localparam logic [TW-1:0] HC_LAST    = TW'(HOLD_TICKS - 1);
  localparam logic [LW-1:0] LAT_LAST   = LW'(PRED_LAT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MEASURE = 3'd1,
    S_PREDICT = 3'd2,
    S_WAIT    = 3'd3,
    S_CLOSED  = 3'd4,
    S_CLEAR   = 3'd5
  } state_e;

  state_e        r_state;
  logic [TW-1:0] r_cnt;
  logic [TW-1:0] r_dn;
  logic [TW-1:0] r_hc;
  logic [LW-1:0] r_lat;
  logic [TW-1:0] r_meas_time;
  logic          r_pred_start;
  logic          r_gate_close;
  logic          r_busy;
  logic          r_err;
  logic          r_s1_q;
  logic          r_s2_q;
  logic          r_s3_q;

  logic w_s1_rise;
  logic w_s2_rise;
  logic w_s3_rise;

  assign w_s1_rise = bus.s1 & ~r_s1_q;
  assign w_s2_rise = bus.s2 & ~r_s2_q;
  assign w_s3_rise = bus.s3 & ~r_s3_q;

  // Previous-sample registers for rise detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_q <= 1'b0;
      r_s2_q <= 1'b0;
      r_s3_q <= 1'b0;
    end else begin
      r_s1_q <= bus.s1;
      r_s2_q <= bus.s2;
      r_s3_q <= bus.s3;
    end
  end

  // Sequencer FSM; busy and gate_close are registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_dn         <= '0;
      r_hc         <= '0;
      r_lat        <= '0;
      r_meas_time  <= '0;
      r_pred_start <= 1'b0;
      r_gate_close <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_pred_start <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_s1_rise) begin
            r_state <= S_MEASURE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end

        // s2 wins over a coincident tick; a zero count is reported as 1
        S_MEASURE: begin
          if (w_s2_rise) begin
            r_meas_time  <= (r_cnt == '0) ? TW'(1) : r_cnt;
            r_pred_start <= 1'b1;
            r_lat        <= '0;
            r_state      <= S_PREDICT;
          end else if (bus.tick) begin
            r_cnt <= r_cnt + TW'(1);
            if (r_cnt == CNT_PRESAT) begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end

        S_PREDICT: begin
          if (r_lat == LAT_LAST) begin
            r_dn <= bus.pred_time;
            if (bus.pred_time == '0) begin
              r_state      <= S_CLOSED;
              r_gate_close <= 1'b1;
            end else begin
              r_state <= S_WAIT;
            end
          end else begin
            r_lat <= r_lat + LW'(1);
          end
        end

        // Early s3 is a safety override and closes immediately
        S_WAIT: begin
          if (w_s3_rise) begin
            r_state      <= S_CLOSED;
            r_gate_close <= 1'b1;
          end else if (bus.tick) begin
            if (r_dn <= TW'(1)) begin
              r_dn         <= '0;
              r_state      <= S_CLOSED;
              r_gate_close <= 1'b1;
            end else begin
              r_dn <= r_dn - TW'(1);
            end
          end
        end

        S_CLOSED: begin
          r_gate_close <= 1'b1;
          if (w_s3_rise) begin
            r_state <= S_CLEAR;
            r_hc    <= '0;
          end
        end

        S_CLEAR: begin
          if (w_s3_rise) begin
            r_hc <= '0;
          end else if (bus.tick) begin
            if (r_hc == HC_LAST) begin
              r_state      <= S_IDLE;
              r_gate_close <= 1'b0;
              r_busy       <= 1'b0;
            end else begin
              r_hc <= r_hc + TW'(1);
            end
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_gate_close <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.meas_time  = r_meas_time;
  assign bus.pred_start = r_pred_start;
  assign bus.gate_close = r_gate_close;
  assign bus.busy       = r_busy;
  assign bus.state      = r_state;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_crossing_sequencer.sv
// Directed bench: nominal cycle, zero interval, early train, coincident events,
// async reset on a 19-bit/HOLD=3 instance, and timeout on a 4-bit instance.
module tb_crossing_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  crossing_sequencer_if #(.TW(19)) ia ();
  crossing_sequencer_if #(.TW(4))  ib ();

  crossing_sequencer #(.TW(19), .PRED_LAT(1), .HOLD_TICKS(3)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (ia.slave)
  );

  crossing_sequencer #(.TW(4), .PRED_LAT(1), .HOLD_TICKS(3)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (ib.slave)
  );

  logic [18:0] pred_val_a = '0;
  int          n_ps_a = 0;
  int          n_ps_b = 0;
  int          n_vec  = 0;
  int          n_bad  = 0;

  // Predictor model: pred_time valid one clk after pred_start
  always @(posedge clk or posedge rst) begin
    if (rst) ia.pred_time <= '0;
    else if (ia.pred_start) ia.pred_time <= pred_val_a;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) ib.pred_time <= '0;
    else if (ib.pred_start) ib.pred_time <= 4'd5;
  end

  always @(posedge clk) begin
    if (ia.pred_start) n_ps_a <= n_ps_a + 1;
    if (ib.pred_start) n_ps_b <= n_ps_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_a(input int n);
    for (int i = 0; i < n; i++) begin
      ia.tick = 1'b1;
      step();
      ia.tick = 1'b0;
    end
  endtask

  task automatic tick_b(input int n);
    for (int i = 0; i < n; i++) begin
      ib.tick = 1'b1;
      step();
      ib.tick = 1'b0;
    end
  endtask

  initial begin
    ia.tick = 1'b0; ia.s1 = 1'b0; ia.s2 = 1'b0; ia.s3 = 1'b0;
    ib.tick = 1'b0; ib.s1 = 1'b0; ib.s2 = 1'b0; ib.s3 = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_state", 32'(ia.state), 32'd0);
    check("rst_gate", 32'(ia.gate_close), 32'd0);
    check("rst_busy", 32'(ia.busy), 32'd0);
    check("rst_err", 32'(ia.err), 32'd0);
    check("rst_ps", 32'(ia.pred_start), 32'd0);
    check("rst_meas", 32'(ia.meas_time), 32'd0);

    // Nominal cycle: 42 ticks, prediction 10, hold 3
    pred_val_a = 19'd10;
    ia.s1 = 1'b1;
    step();
    check("nom_measure", 32'(ia.state), 32'd1);
    check("nom_busy", 32'(ia.busy), 32'd1);
    ia.s1 = 1'b0;
    tick_a(42);
    ia.s2 = 1'b1;
    step();
    check("nom_ps", 32'(ia.pred_start), 32'd1);
    check("nom_meas", 32'(ia.meas_time), 32'd42);
    check("nom_predict", 32'(ia.state), 32'd2);
    ia.s2 = 1'b0;
    step();
    check("nom_ps_low", 32'(ia.pred_start), 32'd0);
    step();
    check("nom_wait", 32'(ia.state), 32'd3);
    tick_a(9);
    check("nom_gate_9", 32'(ia.gate_close), 32'd0);
    check("nom_wait_9", 32'(ia.state), 32'd3);
    tick_a(1);
    check("nom_gate_10", 32'(ia.gate_close), 32'd1);
    check("nom_closed", 32'(ia.state), 32'd4);
    check("nom_ps_count", 32'(n_ps_a), 32'd1);
    ia.s3 = 1'b1;
    step();
    check("nom_clear", 32'(ia.state), 32'd5);
    ia.s3 = 1'b0;
    tick_a(2);
    check("nom_hold_gate", 32'(ia.gate_close), 32'd1);
    tick_a(1);
    check("nom_done_gate", 32'(ia.gate_close), 32'd0);
    check("nom_done_state", 32'(ia.state), 32'd0);
    check("nom_done_busy", 32'(ia.busy), 32'd0);

    // s1+s2 together, then zero-interval s2 with prediction 0
    pred_val_a = 19'd0;
    ia.s1 = 1'b1;
    ia.s2 = 1'b1;
    step();
    check("coin_measure", 32'(ia.state), 32'd1);
    check("coin_no_ps", 32'(ia.pred_start), 32'd0);
    ia.s1 = 1'b0;
    ia.s2 = 1'b0;
    step();
    ia.s2 = 1'b1;
    step();
    check("zero_meas", 32'(ia.meas_time), 32'd1);
    check("zero_ps", 32'(ia.pred_start), 32'd1);
    ia.s2 = 1'b0;
    step();
    step();
    check("zero_closed", 32'(ia.state), 32'd4);
    check("zero_gate", 32'(ia.gate_close), 32'd1);
    ia.s3 = 1'b1;
    step();
    ia.s3 = 1'b0;
    tick_a(3);
    check("zero_idle", 32'(ia.state), 32'd0);

    // Early train: s3 while dn=7
    pred_val_a = 19'd20;
    ia.s1 = 1'b1;
    step();
    ia.s1 = 1'b0;
    tick_a(3);
    ia.s2 = 1'b1;
    step();
    check("early_meas", 32'(ia.meas_time), 32'd3);
    ia.s2 = 1'b0;
    step();
    step();
    tick_a(13);
    check("early_wait", 32'(ia.state), 32'd3);
    check("early_gate0", 32'(ia.gate_close), 32'd0);
    ia.s3 = 1'b1;
    step();
    check("early_closed", 32'(ia.state), 32'd4);
    check("early_gate1", 32'(ia.gate_close), 32'd1);
    step();
    check("early_held", 32'(ia.state), 32'd4);
    ia.s3 = 1'b0;
    tick_a(2);
    check("early_still", 32'(ia.state), 32'd4);
    ia.s3 = 1'b1;
    step();
    check("early_clear", 32'(ia.state), 32'd5);
    ia.s3 = 1'b0;
    tick_a(3);
    check("early_idle", 32'(ia.state), 32'd0);

    // tick and s2 rise together with cnt=5
    pred_val_a = 19'd0;
    ia.s1 = 1'b1;
    step();
    ia.s1 = 1'b0;
    tick_a(5);
    ia.tick = 1'b1;
    ia.s2 = 1'b1;
    step();
    ia.tick = 1'b0;
    check("tick_s2_meas", 32'(ia.meas_time), 32'd5);
    check("tick_s2_ps", 32'(ia.pred_start), 32'd1);
    ia.s2 = 1'b0;
    step();
    step();
    check("tick_s2_closed", 32'(ia.state), 32'd4);

    // Async reset in CLEAR
    ia.s3 = 1'b1;
    step();
    ia.s3 = 1'b0;
    tick_a(1);
    check("pre_rst_state", 32'(ia.state), 32'd5);
    check("pre_rst_gate", 32'(ia.gate_close), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_gate", 32'(ia.gate_close), 32'd0);
    check("arst_state", 32'(ia.state), 32'd0);
    check("arst_err", 32'(ia.err), 32'd0);
    check("arst_busy", 32'(ia.busy), 32'd0);
    step();
    rst = 1'b0;
    step();
    ia.s1 = 1'b1;
    step();
    ia.s1 = 1'b0;
    check("post_rst_measure", 32'(ia.state), 32'd1);
    tick_a(2);
    ia.s2 = 1'b1;
    step();
    ia.s2 = 1'b0;
    check("post_rst_meas", 32'(ia.meas_time), 32'd2);

    // Timeout on the 4-bit instance: 15 ticks without s2
    ib.s1 = 1'b1;
    step();
    ib.s1 = 1'b0;
    check("to_measure", 32'(ib.state), 32'd1);
    tick_b(14);
    check("to_14_state", 32'(ib.state), 32'd1);
    check("to_14_err", 32'(ib.err), 32'd0);
    tick_b(1);
    check("to_err", 32'(ib.err), 32'd1);
    check("to_idle", 32'(ib.state), 32'd0);
    check("to_gate", 32'(ib.gate_close), 32'd0);
    step();
    step();
    check("to_err_hold", 32'(ib.err), 32'd1);
    check("to_no_ps", 32'(n_ps_b), 32'd0);
    ib.s1 = 1'b1;
    step();
    ib.s1 = 1'b0;
    check("to_err_clr", 32'(ib.err), 32'd0);
    check("to_restart", 32'(ib.state), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
